// File: rtl/ifft_n4_base_n2.sv
`default_nettype none
// ============================================================================
// Module   : ifft_n4_base_n2
// Brief    : Streaming 4-point radix-2 inverse DFT, serial in / serial out.
// Revision : 1.0 - initial release
// ============================================================================
module ifft_n4_base_n2 #(
    parameter int DATA_WIDTH = 33,
    parameter bit SCALE_EN   = 1'b0
) (
    input  logic                  sys_clk_i,
    input  logic                  rst_n_i,
    input  logic                  data_in_flag_i,
    input  logic [DATA_WIDTH-1:0] xk_real_i,
    input  logic [DATA_WIDTH-1:0] xk_imag_i,
    output logic                  data_out_flag_o,
    output logic                  data_out_valid_o,
    output logic [DATA_WIDTH+1:0] xn_real_o,
    output logic [DATA_WIDTH+1:0] xn_imag_o,
    output logic                  frame_abort_o
);

    localparam int S1_W  = DATA_WIDTH + 1;
    localparam int OUT_W = DATA_WIDTH + 2;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input collector
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] xr_q [4];
    logic [DATA_WIDTH-1:0] xr_d [4];
    logic [DATA_WIDTH-1:0] xi_q [4];
    logic [DATA_WIDTH-1:0] xi_d [4];
    logic                  full_q, full_d;
    logic                  abort_q, abort_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        full_d  = 1'b0;
        abort_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            xr_d[i] = xr_q[i];
            xi_d[i] = xi_q[i];
        end
        if (data_in_flag_i) begin
            // A flag always starts a fresh frame; a partial one is dropped.
            abort_d = (state_q == ST_COLLECT);
            xr_d[0] = xk_real_i;
            xi_d[0] = xk_imag_i;
            state_d = ST_COLLECT;
            idx_d   = 2'd1;
        end else if (state_q == ST_COLLECT) begin
            xr_d[idx_q] = xk_real_i;
            xi_d[idx_q] = xk_imag_i;
            idx_d       = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                state_d = ST_IDLE;
                full_d  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 butterflies
    // ------------------------------------------------------------------
    function automatic logic signed [S1_W-1:0] ext1(input logic [DATA_WIDTH-1:0] v);
        return {v[DATA_WIDTH-1], v};
    endfunction

    logic signed [S1_W-1:0] a0r_q, a0i_q, a1r_q, a1i_q;
    logic signed [S1_W-1:0] b0r_q, b0i_q, b1r_q, b1i_q;
    logic signed [S1_W-1:0] a0r_d, a0i_d, a1r_d, a1i_d;
    logic signed [S1_W-1:0] b0r_d, b0i_d, b1r_d, b1i_d;
    logic                   s1_vld_q, s1_vld_d;

    always_comb begin
        s1_vld_d = full_q;
        a0r_d = a0r_q;
        a0i_d = a0i_q;
        a1r_d = a1r_q;
        a1i_d = a1i_q;
        b0r_d = b0r_q;
        b0i_d = b0i_q;
        b1r_d = b1r_q;
        b1i_d = b1i_q;
        if (full_q) begin
            a0r_d = ext1(xr_q[0]) + ext1(xr_q[2]);
            a0i_d = ext1(xi_q[0]) + ext1(xi_q[2]);
            a1r_d = ext1(xr_q[0]) - ext1(xr_q[2]);
            a1i_d = ext1(xi_q[0]) - ext1(xi_q[2]);
            b0r_d = ext1(xr_q[1]) + ext1(xr_q[3]);
            b0i_d = ext1(xi_q[1]) + ext1(xi_q[3]);
            b1r_d = ext1(xr_q[1]) - ext1(xr_q[3]);
            b1i_d = ext1(xi_q[1]) - ext1(xi_q[3]);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 (twiddle +j) with optional divide-by-4, feeding the serializer
    // ------------------------------------------------------------------
    function automatic logic signed [OUT_W-1:0] ext2(input logic signed [S1_W-1:0] v);
        return {v[S1_W-1], v};
    endfunction

    function automatic logic signed [OUT_W-1:0] scl(input logic signed [OUT_W-1:0] v);
        if (SCALE_EN) begin
            return v >>> 2;
        end
        return v;
    endfunction

    logic signed [OUT_W-1:0] w_x0r, w_x0i, w_x1r, w_x1i;
    logic signed [OUT_W-1:0] w_x2r, w_x2i, w_x3r, w_x3i;

    always_comb begin
        w_x0r = scl(ext2(a0r_q) + ext2(b0r_q));
        w_x0i = scl(ext2(a0i_q) + ext2(b0i_q));
        w_x2r = scl(ext2(a0r_q) - ext2(b0r_q));
        w_x2i = scl(ext2(a0i_q) - ext2(b0i_q));
        w_x1r = scl(ext2(a1r_q) - ext2(b1i_q));
        w_x1i = scl(ext2(a1i_q) + ext2(b1r_q));
        w_x3r = scl(ext2(a1r_q) + ext2(b1i_q));
        w_x3i = scl(ext2(a1i_q) - ext2(b1r_q));
    end

    // ------------------------------------------------------------------
    // Output serializer
    // ------------------------------------------------------------------
    logic signed [OUT_W-1:0] shr_q [3];
    logic signed [OUT_W-1:0] shr_d [3];
    logic signed [OUT_W-1:0] shi_q [3];
    logic signed [OUT_W-1:0] shi_d [3];
    logic [1:0]              cnt_q, cnt_d;
    logic                    out_flag_q, out_flag_d;
    logic                    out_valid_q, out_valid_d;
    logic [OUT_W-1:0]        out_re_q, out_re_d;
    logic [OUT_W-1:0]        out_im_q, out_im_d;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            shr_d[i] = shr_q[i];
            shi_d[i] = shi_q[i];
        end
        cnt_d       = cnt_q;
        out_flag_d  = 1'b0;
        out_valid_d = 1'b0;
        out_re_d    = '0;
        out_im_d    = '0;
        if (s1_vld_q) begin
            out_flag_d  = 1'b1;
            out_valid_d = 1'b1;
            out_re_d    = w_x0r;
            out_im_d    = w_x0i;
            shr_d[0]    = w_x1r;
            shi_d[0]    = w_x1i;
            shr_d[1]    = w_x2r;
            shi_d[1]    = w_x2i;
            shr_d[2]    = w_x3r;
            shi_d[2]    = w_x3i;
            cnt_d       = 2'd3;
        end else if (cnt_q != 2'd0) begin
            out_valid_d = 1'b1;
            out_re_d    = shr_q[0];
            out_im_d    = shi_q[0];
            shr_d[0]    = shr_q[1];
            shi_d[0]    = shi_q[1];
            shr_d[1]    = shr_q[2];
            shi_d[1]    = shi_q[2];
            shr_d[2]    = '0;
            shi_d[2]    = '0;
            cnt_d       = cnt_q - 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            full_q      <= 1'b0;
            abort_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                xr_q[i] <= '0;
                xi_q[i] <= '0;
            end
            s1_vld_q    <= 1'b0;
            a0r_q       <= '0;
            a0i_q       <= '0;
            a1r_q       <= '0;
            a1i_q       <= '0;
            b0r_q       <= '0;
            b0i_q       <= '0;
            b1r_q       <= '0;
            b1i_q       <= '0;
            for (int i = 0; i < 3; i++) begin
                shr_q[i] <= '0;
                shi_q[i] <= '0;
            end
            cnt_q       <= 2'd0;
            out_flag_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            full_q      <= full_d;
            abort_q     <= abort_d;
            for (int i = 0; i < 4; i++) begin
                xr_q[i] <= xr_d[i];
                xi_q[i] <= xi_d[i];
            end
            s1_vld_q    <= s1_vld_d;
            a0r_q       <= a0r_d;
            a0i_q       <= a0i_d;
            a1r_q       <= a1r_d;
            a1i_q       <= a1i_d;
            b0r_q       <= b0r_d;
            b0i_q       <= b0i_d;
            b1r_q       <= b1r_d;
            b1i_q       <= b1i_d;
            for (int i = 0; i < 3; i++) begin
                shr_q[i] <= shr_d[i];
                shi_q[i] <= shi_d[i];
            end
            cnt_q       <= cnt_d;
            out_flag_q  <= out_flag_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    assign data_out_flag_o  = out_flag_q;
    assign data_out_valid_o = out_valid_q;
    assign xn_real_o        = out_re_q;
    assign xn_imag_o        = out_im_q;
    assign frame_abort_o    = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_ifft_n4_base_n2.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifft_n4_base_n2
// Brief    : Self-checking bench: unscaled and scaled instances, DATA_WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifft_n4_base_n2;

    localparam int DW = 8;
    localparam int OW = DW + 2;

    logic          clk = 1'b1;
    logic          rst_n;
    logic          flag_in;
    logic [DW-1:0] xr_in, xi_in;
    logic          fa, va, aa, fb, vb, ab;
    logic [OW-1:0] ra, ia, rb, ib;

    always #5 clk = ~clk;

    ifft_n4_base_n2 #(.DATA_WIDTH(DW), .SCALE_EN(1'b0)) dut_a (
        .sys_clk_i(clk), .rst_n_i(rst_n), .data_in_flag_i(flag_in),
        .xk_real_i(xr_in), .xk_imag_i(xi_in),
        .data_out_flag_o(fa), .data_out_valid_o(va),
        .xn_real_o(ra), .xn_imag_o(ia), .frame_abort_o(aa));

    ifft_n4_base_n2 #(.DATA_WIDTH(DW), .SCALE_EN(1'b1)) dut_b (
        .sys_clk_i(clk), .rst_n_i(rst_n), .data_in_flag_i(flag_in),
        .xk_real_i(xr_in), .xk_imag_i(xi_in),
        .data_out_flag_o(fb), .data_out_valid_o(vb),
        .xn_real_o(rb), .xn_imag_o(ib), .frame_abort_o(ab));

    typedef int arr4_t [4];
    typedef struct { arr4_t xr; arr4_t xi; arr4_t er; arr4_t ei; arr4_t sr; arr4_t si; } vec_t;
    typedef struct { bit flag; bit valid; bit abort; int re0; int im0; int re1; int im1; } exp_t;

    exp_t  sched [int];
    int    cyc, n_checks, n_errors;
    int    col_n, col_start;
    arr4_t col_r, col_i;
    vec_t  vecs [5];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Direct inverse DFT: x[n] = sum_k X[k] * j^(n*k)
    task automatic idft(input arr4_t r, input arr4_t i, output arr4_t or_, output arr4_t oi);
        for (int n = 0; n < 4; n++) begin
            or_[n] = 0;
            oi[n]  = 0;
            for (int k = 0; k < 4; k++) begin
                case ((n * k) % 4)
                    0: begin or_[n] += r[k]; oi[n] += i[k]; end
                    1: begin or_[n] -= i[k]; oi[n] += r[k]; end
                    2: begin or_[n] -= r[k]; oi[n] -= i[k]; end
                    default: begin or_[n] += i[k]; oi[n] -= r[k]; end
                endcase
            end
        end
    endtask

    function automatic exp_t get_slot(input int t);
        exp_t e;
        e = '{default: 0};
        if (sched.exists(t)) e = sched[t];
        return e;
    endfunction

    task automatic model_ingest();
        exp_t  e;
        arr4_t orr, oii;
        if (flag_in) begin
            if (col_n > 0) begin
                e = get_slot(cyc + 1);
                e.abort = 1'b1;
                sched[cyc + 1] = e;
            end
            col_n     = 1;
            col_start = cyc;
            col_r[0]  = int'($signed(xr_in));
            col_i[0]  = int'($signed(xi_in));
        end else if (col_n > 0) begin
            col_r[col_n] = int'($signed(xr_in));
            col_i[col_n] = int'($signed(xi_in));
            col_n++;
            if (col_n == 4) begin
                idft(col_r, col_i, orr, oii);
                for (int n = 0; n < 4; n++) begin
                    e = get_slot(col_start + 6 + n);
                    e.valid = 1'b1;
                    e.flag  = (n == 0);
                    e.re0 = orr[n];
                    e.im0 = oii[n];
                    e.re1 = orr[n] >>> 2;
                    e.im1 = oii[n] >>> 2;
                    sched[col_start + 6 + n] = e;
                end
                col_n = 0;
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        e = '{default: 0};
        if (!rst_n) begin
            col_n = 0;
            sched.delete();
        end else begin
            model_ingest();
            e = get_slot(cyc);
            if (sched.exists(cyc)) sched.delete(cyc);
        end
        chk("mdl_abort_a", int'(aa), int'(e.abort));
        chk("mdl_abort_b", int'(ab), int'(e.abort));
        chk("mdl_flag_a",  int'(fa), int'(e.flag));
        chk("mdl_flag_b",  int'(fb), int'(e.flag));
        chk("mdl_valid_a", int'(va), int'(e.valid));
        chk("mdl_valid_b", int'(vb), int'(e.valid));
        chk("mdl_re_a", int'($signed(ra)), e.re0);
        chk("mdl_im_a", int'($signed(ia)), e.im0);
        chk("mdl_re_b", int'($signed(rb)), e.re1);
        chk("mdl_im_b", int'($signed(ib)), e.im1);
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit f, input int r, input int i);
        flag_in = f;
        xr_in   = DW'(r);
        xi_in   = DW'(i);
    endtask

    function automatic int rnd();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic send(input arr4_t r, input arr4_t i);
        for (int k = 0; k < 4; k++) begin
            drive(k == 0, r[k], i[k]);
            step();
        end
        drive(1'b0, 0, 0);
    endtask

    initial begin
        arr4_t fr [2];
        arr4_t fi [2];
        int    m;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        col_n    = 0;
        rst_n    = 1'b0;
        drive(1'b0, 0, 0);

        vecs[0].xr = '{4, 0, 0, 0};         vecs[0].xi = '{0, 0, 0, 0};
        vecs[0].er = '{4, 4, 4, 4};         vecs[0].ei = '{0, 0, 0, 0};
        vecs[0].sr = '{1, 1, 1, 1};         vecs[0].si = '{0, 0, 0, 0};
        vecs[1].xr = '{0, 4, 0, 0};         vecs[1].xi = '{0, 0, 0, 0};
        vecs[1].er = '{4, 0, -4, 0};        vecs[1].ei = '{0, 4, 0, -4};
        vecs[1].sr = '{1, 0, -1, 0};        vecs[1].si = '{0, 1, 0, -1};
        vecs[2].xr = '{-3, 0, 0, 0};        vecs[2].xi = '{0, 0, 0, 0};
        vecs[2].er = '{-3, -3, -3, -3};     vecs[2].ei = '{0, 0, 0, 0};
        vecs[2].sr = '{-1, -1, -1, -1};     vecs[2].si = '{0, 0, 0, 0};
        vecs[3].xr = '{-128, -128, -128, -128}; vecs[3].xi = '{-128, -128, -128, -128};
        vecs[3].er = '{-512, 0, 0, 0};      vecs[3].ei = '{-512, 0, 0, 0};
        vecs[3].sr = '{-128, 0, 0, 0};      vecs[3].si = '{-128, 0, 0, 0};
        vecs[4].xr = '{1, 2, 3, 4};         vecs[4].xi = '{0, 0, 0, 0};
        vecs[4].er = '{10, -2, -2, -2};     vecs[4].ei = '{0, -2, 0, 2};
        vecs[4].sr = '{2, -1, -1, -1};      vecs[4].si = '{0, -1, 0, 0};

        repeat (3) step();
        chk("rst_valid", int'(va), 0);
        chk("rst_re", int'($signed(ra)), 0);
        rst_n = 1'b1;
        repeat (2) step();

        // Table vectors: x0..x3 at frame start +6..+9
        for (int v = 0; v < 5; v++) begin
            send(vecs[v].xr, vecs[v].xi);
            repeat (2) step();
            for (int n = 0; n < 4; n++) begin
                chk("tbl_flag",  int'(fa), int'(n == 0));
                chk("tbl_valid", int'(va), 1);
                chk("tbl_re_a", int'($signed(ra)), vecs[v].er[n]);
                chk("tbl_im_a", int'($signed(ia)), vecs[v].ei[n]);
                chk("tbl_re_b", int'($signed(rb)), vecs[v].sr[n]);
                chk("tbl_im_b", int'($signed(ib)), vecs[v].si[n]);
                step();
            end
            chk("tbl_valid_end", int'(va), 0);
            step();
        end

        // Back-to-back frames: flags at 0 and 4
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 4; k++) begin
                fr[f][k] = rnd();
                fi[f][k] = rnd();
            end
        for (int t = 0; t < 15; t++) begin
            if (t < 8) drive(t % 4 == 0, fr[t / 4][t % 4], fi[t / 4][t % 4]);
            else       drive(1'b0, 0, 0);
            if (t >= 6 && t <= 13) begin
                chk("b2b_valid", int'(va), 1);
                chk("b2b_flag",  int'(fa), int'(t == 6 || t == 10));
            end
            step();
        end

        // Abort: flags at 0 and 2, only second frame emerges with flag at 8
        for (int t = 0; t < 13; t++) begin
            if (t < 6) drive(t == 0 || t == 2, rnd(), rnd());
            else       drive(1'b0, 0, 0);
            if (t >= 1 && t <= 4) chk("abort_pulse", int'(aa), int'(t == 3));
            if (t == 6 || t == 7) chk("abort_nooutput", int'(va), 0);
            if (t >= 8 && t <= 11) begin
                chk("abort_valid", int'(va), 1);
                chk("abort_flag",  int'(fa), int'(t == 8));
            end
            step();
        end

        // Flag in the X[3] slot restarts; the first frame never completes
        for (int t = 0; t < 11; t++) begin
            if (t < 7) drive(t == 0 || t == 3, rnd(), rnd());
            else       drive(1'b0, 0, 0);
            if (t == 4) chk("x3_abort", int'(aa), 1);
            if (t >= 6 && t <= 8) chk("x3_nooutput", int'(va), 0);
            if (t == 9) chk("x3_flag", int'(fa), 1);
            step();
        end
        repeat (4) step();

        // Reset at cycle 7 of a frame
        for (int k = 0; k < 4; k++) begin
            fr[0][k] = rnd();
            fi[0][k] = rnd();
        end
        send(fr[0], fi[0]);
        repeat (3) step();
        chk("prerst_valid", int'(va), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(va), 0);
        chk("midrst_re", int'($signed(ra)), 0);
        chk("midrst_im_b", int'($signed(ib)), 0);
        step();
        rst_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            chk("postrst_valid", int'(va), 0);
            step();
        end

        // Randomized stream checked against the model every cycle
        for (int it = 0; it < 120; it++) begin
            m = int'($urandom_range(0, 9));
            if (m <= 6) begin
                for (int k = 0; k < 4; k++) begin
                    fr[0][k] = rnd();
                    fi[0][k] = rnd();
                end
                send(fr[0], fi[0]);
            end else if (m == 7) begin
                repeat (int'($urandom_range(1, 3))) begin
                    drive(1'b0, rnd(), rnd());
                    step();
                end
            end else if (m == 8) begin
                drive(1'b1, rnd(), rnd());
                step();
                repeat (int'($urandom_range(0, 2))) begin
                    drive(1'b0, rnd(), rnd());
                    step();
                end
            end else begin
                drive(($urandom_range(0, 1) == 1), rnd(), rnd());
                step();
            end
        end
        drive(1'b0, 0, 0);
        repeat (12) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
